// File: rtl/uart_tx8.sv
// Serial frame transmitter: start, 8 data bits LSB-first, optional even parity, stop.
// First bit on O one edge after accept; READY low for the whole frame, then one idle cycle.
module uart_tx8 #(
    parameter int DIVISOR = 4,
    parameter int PARITY  = 0
) (
    input  logic       CLK,
    input  logic       ASYNCRESET,
    input  logic [7:0] I,
    input  logic       VALID,
    output logic       READY,
    output logic       O,
    output logic       BUSY
);
    localparam int DW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(DIVISOR - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [DW-1:0] div_cnt, div_nxt;
    logic [7:0]    data, data_nxt;
    logic          o_nxt, ready_nxt;
    logic          last;

    assign last = (div_cnt == DIV_MAX);

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state   <= IDLE;
            bit_idx <= 3'd0;
            div_cnt <= '0;
            data    <= 8'd0;
            O       <= 1'b1;
            READY   <= 1'b1;
            BUSY    <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_idx <= bit_nxt;
            div_cnt <= div_nxt;
            data    <= data_nxt;
            O       <= o_nxt;
            READY   <= ready_nxt;
            BUSY    <= ~ready_nxt;
        end
    end

    // O and READY are computed for the state being entered so they register in step with it.
    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_idx;
        div_nxt   = div_cnt;
        data_nxt  = data;
        o_nxt     = O;
        ready_nxt = READY;
        case (state)
            IDLE: begin
                o_nxt     = 1'b1;
                ready_nxt = 1'b1;
                div_nxt   = '0;
                if (VALID) begin
                    data_nxt  = I;
                    state_nxt = START;
                    o_nxt     = 1'b0;
                    ready_nxt = 1'b0;
                end
            end
            START: begin
                if (last) begin
                    div_nxt   = '0;
                    bit_nxt   = 3'd0;
                    state_nxt = DATA;
                    o_nxt     = data[0];
                end else begin
                    div_nxt = div_cnt + DW'(1);
                end
            end
            DATA: begin
                if (last) begin
                    div_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        if (PARITY == 1) begin
                            state_nxt = PAR;
                            o_nxt     = ^data;
                        end else begin
                            state_nxt = STOP;
                            o_nxt     = 1'b1;
                        end
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                        o_nxt   = data[bit_idx + 3'd1];
                    end
                end else begin
                    div_nxt = div_cnt + DW'(1);
                end
            end
            PAR: begin
                if (last) begin
                    div_nxt   = '0;
                    state_nxt = STOP;
                    o_nxt     = 1'b1;
                end else begin
                    div_nxt = div_cnt + DW'(1);
                end
            end
            STOP: begin
                if (last) begin
                    div_nxt   = '0;
                    state_nxt = IDLE;
                    o_nxt     = 1'b1;
                    ready_nxt = 1'b1;
                end else begin
                    div_nxt = div_cnt + DW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                div_nxt   = '0;
                bit_nxt   = 3'd0;
                o_nxt     = 1'b1;
                ready_nxt = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx8.sv
// Directed bench for uart_tx8: three instances cover DIVISOR=4/PARITY=0, DIVISOR=4/PARITY=1, DIVISOR=1/PARITY=0.
module tb_uart_tx8;
    logic       clk;
    logic       rst;
    logic [7:0] i4, i4p, i1;
    logic       v4, v4p, v1;
    logic       r4, r4p, r1;
    logic       o4, o4p, o1;
    logic       b4, b4p, b1;

    logic [1:0] sel;
    logic       o_s, ready_s, busy_s;

    int total = 0;
    int bad   = 0;

    uart_tx8 #(.DIVISOR(4), .PARITY(0)) u4 (
        .CLK(clk), .ASYNCRESET(rst), .I(i4), .VALID(v4), .READY(r4), .O(o4), .BUSY(b4)
    );
    uart_tx8 #(.DIVISOR(4), .PARITY(1)) u4p (
        .CLK(clk), .ASYNCRESET(rst), .I(i4p), .VALID(v4p), .READY(r4p), .O(o4p), .BUSY(b4p)
    );
    uart_tx8 #(.DIVISOR(1), .PARITY(0)) u1 (
        .CLK(clk), .ASYNCRESET(rst), .I(i1), .VALID(v1), .READY(r1), .O(o1), .BUSY(b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        o_s = o4; ready_s = r4; busy_s = b4;
        case (sel)
            2'd1: begin o_s = o4p; ready_s = r4p; busy_s = b4p; end
            2'd2: begin o_s = o1;  ready_s = r1;  busy_s = b1;  end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic v);
        case (sel)
            2'd0: begin i4 = d;  v4 = v;  end
            2'd1: begin i4p = d; v4p = v; end
            default: begin i1 = d; v1 = v; end
        endcase
    endtask

    task automatic set_valid(input logic v);
        case (sel)
            2'd0: v4 = v;
            2'd1: v4p = v;
            default: v1 = v;
        endcase
    endtask

    // Call right after the accept edge; f[0] is the start bit, f[nb-1] the stop bit.
    task automatic check_frame(input string tag, input logic [10:0] f, input int nb, input int d,
                               input int drop_at);
        for (int j = 0; j < nb * d; j++) begin
            if (j == drop_at) set_valid(1'b0);
            chk({tag, "_o"}, o_s, f[j / d]);
            chk({tag, "_ready"}, ready_s, 1'b0);
            chk({tag, "_busy"}, busy_s, 1'b1);
            tick();
        end
        chk({tag, "_end_o"}, o_s, 1'b1);
        chk({tag, "_end_ready"}, ready_s, 1'b1);
        chk({tag, "_end_busy"}, busy_s, 1'b0);
    endtask

    initial begin
        sel = 2'd0;
        rst = 1'b1;
        i4 = 8'h00; i4p = 8'h00; i1 = 8'h00;
        v4 = 1'b0;  v4p = 1'b0;  v1 = 1'b0;
        #2;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #0;
            chk("rst_o", o_s, 1'b1);
            chk("rst_ready", ready_s, 1'b1);
            chk("rst_busy", busy_s, 1'b0);
        end
        tick();
        tick();
        rst = 1'b0;

        // Idle: no VALID for 20 cycles.
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int s = 0; s < 3; s++) begin
                sel = 2'(s);
                #0;
                chk("idle_o", o_s, 1'b1);
                chk("idle_ready", ready_s, 1'b1);
                chk("idle_busy", busy_s, 1'b0);
            end
        end

        // D=4, no parity, A5 -> bits 1,0,1,0,0,1,0,1.
        sel = 2'd0;
        drive(8'hA5, 1'b1);
        tick();
        drive(8'hA5, 1'b0);
        check_frame("a5", {1'b0, 1'b1, 8'hA5, 1'b0}, 10, 4, -1);
        tick();

        // D=4, even parity: 07 has three ones -> parity 1; 03 has two -> parity 0.
        sel = 2'd1;
        drive(8'h07, 1'b1);
        tick();
        drive(8'h07, 1'b0);
        check_frame("p07", {1'b1, 1'b1, 8'h07, 1'b0}, 11, 4, -1);
        tick();
        drive(8'h03, 1'b1);
        tick();
        drive(8'h03, 1'b0);
        check_frame("p03", {1'b1, 1'b0, 8'h03, 1'b0}, 11, 4, -1);
        tick();

        // D=1, VALID held: second accept lands 11 edges after the first.
        sel = 2'd2;
        drive(8'h00, 1'b1);
        tick();
        drive(8'hFF, 1'b1);
        check_frame("b2b00", {1'b0, 1'b1, 8'h00, 1'b0}, 10, 1, -1);
        tick();
        drive(8'hFF, 1'b0);
        check_frame("b2bff", {1'b0, 1'b1, 8'hFF, 1'b0}, 10, 1, -1);
        tick();

        // Captured word frozen: 3C goes out even with FF/VALID driven mid-frame.
        sel = 2'd0;
        drive(8'h3C, 1'b1);
        tick();
        drive(8'hFF, 1'b1);
        check_frame("stab", {1'b0, 1'b1, 8'h3C, 1'b0}, 10, 4, 30);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stab_noacc_ready", ready_s, 1'b1);
            chk("stab_noacc_o", o_s, 1'b1);
        end

        // Reset asserted between edges during data bit 3 (bit 3 of A5 is 0).
        drive(8'hA5, 1'b1);
        tick();
        drive(8'hA5, 1'b0);
        repeat (17) tick();
        chk("mid_bit3", o_s, 1'b0);
        chk("mid_ready", ready_s, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_o", o_s, 1'b1);
        chk("arst_ready", ready_s, 1'b1);
        chk("arst_busy", busy_s, 1'b0);
        drive(8'h81, 1'b1);
        tick();
        chk("rstvalid_ready", ready_s, 1'b1);
        chk("rstvalid_o", o_s, 1'b1);
        #2;
        rst = 1'b0;
        tick();
        drive(8'h81, 1'b0);
        check_frame("post81", {1'b0, 1'b1, 8'h81, 1'b0}, 10, 4, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_tx8.md
# uart_tx8

Serial frame transmitter that consumes the 8-bit parallel word held in the upstream 8-bit register stage. It emits that word on a single line as an asynchronous serial frame: start bit, 8 data bits LSB-first, optional even parity, stop bit. The upstream stage presents the word with a valid/ready handshake, and the block holds its own copy for the whole frame. It is the last stage before the pad.

## Interface

Parameters:
- DIVISOR, default 4: clock cycles per serial bit; legal range 1..65535.
- PARITY, default 0: 0 = no parity bit; 1 = even parity bit inserted after data bit 7.

Ports:
- CLK  in  1  : system clock; all state changes on the rising edge.
- ASYNCRESET  in  1  : asynchronous, active-high reset.
- I  in  8  : parallel data word from the upstream register.
- VALID  in  1  : I holds a word to send.
- READY  out  1  : block can accept a word this cycle.
- O  out  1  : serial line; idles high.
- BUSY  out  1  : a frame is in progress; always equal to ~READY.

## Operation

- All outputs are registered.
- Reset values:
  - While ASYNCRESET is high: O=1, READY=1, BUSY=0, state=IDLE, bit counter=0, divider counter=0.
  - Reset takes effect immediately, without waiting for a clock edge.
- States: IDLE, START, DATA, PAR, STOP.
- IDLE:
  - O=1, READY=1.
  - On a rising edge with VALID=1, capture I into the shift register and go to START (an accept).
  - VALID=0 stays in IDLE.
- START: O=0 for DIVISOR cycles, then go to DATA with bit index 0.
- DATA:
  - O = captured bit[index] for DIVISOR cycles.
  - Index 0..7. After index 7, go to PAR if PARITY=1, else STOP.
- PAR: O = XOR of the 8 captured bits, held for DIVISOR cycles, then STOP.
- STOP: O=1 for DIVISOR cycles, then IDLE.
- Divider counter:
  - Counts 0..DIVISOR-1 in every non-IDLE state and wraps to 0 on each bit boundary.
  - Width is ceil(log2(DIVISOR)), minimum 1 bit.
  - DIVISOR=1 means one cycle per bit.
- Captured data is frozen for the whole frame:
  - Changes on I or VALID while READY=0 are ignored.
  - No accept occurs while READY=0.
- Reset mid-frame:
  - Aborts the frame; O returns to 1 immediately.
  - The partial frame is discarded and never resumed.
- VALID asserted during reset is ignored. The first accept can occur on the first rising edge after ASYNCRESET falls.

## Timing

- Let edge E0 be the accept edge. N = 10 with PARITY=0, 11 with PARITY=1. D = DIVISOR.
- After E0: O=0, READY=0, BUSY=1. The start bit spans E0..E(D).
- Data bit k is driven on O from E((1+k)·D) to E((2+k)·D).
- The parity bit, if enabled, spans E(9D)..E(10D).
- The stop bit spans E((N-1)·D)..E(N·D). After E(N·D): state=IDLE, READY=1, O=1.
- READY is low for exactly N·D cycles per frame.
- Back-to-back frames:
  - The earliest next accept is E(N·D+1), so consecutive frames are separated by D+1 high cycles (stop bit plus one idle cycle).
  - With VALID held high, frames repeat with period N·D+1 cycles.
- Latency from accept edge to the falling edge of the start bit on O: 1 edge (visible right after E0).

## Test plan

- DIVISOR=4, PARITY=0, I=8'hA5, VALID pulsed one cycle in IDLE:
  - O = 0×4, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1×4.
  - READY low for 40 cycles, BUSY=~READY throughout.
- DIVISOR=4, PARITY=1:
  - I=8'h07 → parity bit 1, frame 44 cycles.
  - I=8'h03 → parity bit 0.
- DIVISOR=1, PARITY=0, VALID held high with I=8'h00 then 8'hFF:
  - Frames of 10 cycles; start of frame 2 exactly 11 cycles after the first accept.
  - Data 0×8 then 1×8.
- Data stability: accept I=8'h3C, then drive I=8'hFF and VALID=1 during the frame → transmitted bits are still 0,0,1,1,1,1,0,0 and no extra accept occurs.
- Reset mid-frame: DIVISOR=4, assert ASYNCRESET between clock edges during data bit 3 →
  - O=1, READY=1, BUSY=0 immediately, before the next edge.
  - After release, a new accept of 8'h81 sends a clean full frame.
- Idle behaviour: VALID=0 for 20 cycles after reset → O=1, READY=1, BUSY=0 constant.
